data_mem_responder: RTL and testbench

Memory-side responder for the core's data-memory port. Accepts one load/store request at a time over a ready/valid handshake, inserts a configurable number of wait states, performs byte/halfword/word accesses on an internal word-organised RAM, and returns load data already lane-aligned and sign/zero-extended. Sits between the pipeline's MEM stage and on-chip data storage, and also serves as a slow-memory model for stall and forwarding tests.

---
 rtl/data_mem_responder.sv | 268 ++++++++++++++++++++++++++
 tb/tb_data_mem_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-memory responder with wait states, byte lanes and load extension
//
// Purpose: accepts one load/store at a time over req_i/ready_o, waits WAIT_STATES
// cycles, accesses a word-organised RAM with byte enables and returns lane-aligned,
// sign/zero-extended load data with a one-cycle rvalid_o strobe.
//
// Parameters:
//   ADDR_WIDTH  - word-address bits (depth = 2**ADDR_WIDTH 32-bit words)
//   WAIT_STATES - extra cycles between acceptance and response (0..15)
//
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-low reset
//   req_i      - request valid
//   we_i       - 1 = store, 0 = load
//   size_i     - 00 byte, 01 half, 10/11 word
//   unsigned_i - loads: 1 = zero-extend, 0 = sign-extend
//   addr_i     - byte address (upper bits alias)
//   wdata_i    - right-justified store data
//   ready_o    - request can be accepted this cycle
//   rvalid_o   - one-cycle response strobe
//   rdata_o    - load result (0 for stores / errored accesses)
//   err_o      - misaligned-access flag, valid with rvalid_o
//
// Configuration macro: DATA_MEM_MISALIGN_ERR_EN
//   defined   - misaligned accesses flag err_o, suppress stores, return 0
//   undefined - misaligned addresses are force-aligned, err_o tied 0

module data_mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ready_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int AW    = ADDR_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;

    logic            we_q;
    logic [1:0]      size_q;
    logic            uns_q;
    logic [AW-1:0]   addr_q;
    logic [31:0]     wdata_q;

    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [31:0]     mem_q [DEPTH];

    logic            accept;
    logic            commit;

    logic            op_we;
    logic [1:0]      op_size;
    logic            op_uns;
    logic [AW-1:0]   op_addr;
    logic [31:0]     op_wdata;
    logic [1:0]      lane;
    logic [ADDR_WIDTH-1:0] idx;
    logic [31:0]     rd_word;
    logic [31:0]     load_val;
    logic [7:0]      sel_byte;
    logic [15:0]     sel_half;
    logic [3:0]      be;
    logic [31:0]     wd;
    logic            do_write;

    logic            unused_addr;
    assign unused_addr = ^addr_i[31:AW];

    assign accept = rst & req_i & ready_o;

    // The edge that enters RESP is the commit edge: the acceptance edge itself
    // when there are no wait states, otherwise the last BUSY edge.
    generate
        if (WAIT_STATES == 0) begin : g_commit_now
            assign commit = accept;
        end else begin : g_commit_late
            assign commit = rst & (state_q == BUSY) & (cnt_q == 4'd1);
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            default: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = 4'(WAIT_STATES);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Output logic
    always_comb begin
        ready_o  = (state_q != BUSY);
        rvalid_o = (state_q == RESP);
    end

    // Request capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
        end else if (accept) begin
            we_q    <= we_i;
            size_q  <= size_i;
            uns_q   <= unsigned_i;
            addr_q  <= addr_i[AW-1:0];
            wdata_q <= wdata_i;
        end
    end

    // With no wait states the access happens on the acceptance edge, so the
    // operands come straight from the inputs instead of the capture registers.
    always_comb begin
        if (WAIT_STATES == 0) begin
            op_we    = we_i;
            op_size  = size_i;
            op_uns   = unsigned_i;
            op_addr  = addr_i[AW-1:0];
            op_wdata = wdata_i;
        end else begin
            op_we    = we_q;
            op_size  = size_q;
            op_uns   = uns_q;
            op_addr  = addr_q;
            op_wdata = wdata_q;
        end
    end

    always_comb begin
        idx = op_addr[AW-1:2];
`ifdef DATA_MEM_MISALIGN_ERR_EN
        lane  = op_addr[1:0];
        err_d = ((op_size == 2'b01) & op_addr[0]) |
                (op_size[1] & (op_addr[1:0] != 2'b00));
`else
        err_d = 1'b0;
        if (op_size == 2'b01) begin
            lane = {op_addr[1], 1'b0};
        end else if (op_size[1]) begin
            lane = 2'b00;
        end else begin
            lane = op_addr[1:0];
        end
`endif
    end

    // Load path: lane select and extension
    always_comb begin
        rd_word = mem_q[idx];
        case (lane)
            2'd0:    sel_byte = rd_word[7:0];
            2'd1:    sel_byte = rd_word[15:8];
            2'd2:    sel_byte = rd_word[23:16];
            default: sel_byte = rd_word[31:24];
        endcase
        sel_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
        case (op_size)
            2'b00:   load_val = op_uns ? {24'd0, sel_byte}
                                       : {{24{sel_byte[7]}}, sel_byte};
            2'b01:   load_val = op_uns ? {16'd0, sel_half}
                                       : {{16{sel_half[15]}}, sel_half};
            default: load_val = rd_word;
        endcase
    end

    // Store path: replicate data across lanes and enable only the target bytes
    always_comb begin
        case (op_size)
            2'b00: begin
                wd = {4{op_wdata[7:0]}};
                be = 4'b0001 << lane;
            end
            2'b01: begin
                wd = {2{op_wdata[15:0]}};
                be = lane[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wd = op_wdata;
                be = 4'b1111;
            end
        endcase
        do_write = commit & op_we & ~err_d;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (commit) begin
            rdata_d = (op_we | err_d) ? 32'd0 : load_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (commit) begin
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // RAM contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[idx][8*i +: 8] <= wd[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o = rdata_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;

    logic clk;
    logic rst;

    logic        r0_req, r0_we, r0_uns;
    logic [1:0]  r0_size;
    logic [31:0] r0_addr, r0_wdata;
    logic        d0_ready, d0_rvalid, d0_err;
    logic [31:0] d0_rdata;

    logic        r3_req, r3_we, r3_uns;
    logic [1:0]  r3_size;
    logic [31:0] r3_addr, r3_wdata;
    logic        d3_ready, d3_rvalid, d3_err;
    logic [31:0] d3_rdata;

    int checks;
    int errors;

    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_i(r0_req), .we_i(r0_we), .size_i(r0_size), .unsigned_i(r0_uns),
        .addr_i(r0_addr), .wdata_i(r0_wdata),
        .ready_o(d0_ready), .rvalid_o(d0_rvalid), .rdata_o(d0_rdata), .err_o(d0_err)
    );

    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst(rst),
        .req_i(r3_req), .we_i(r3_we), .size_i(r3_size), .unsigned_i(r3_uns),
        .addr_i(r3_addr), .wdata_i(r3_wdata),
        .ready_o(d3_ready), .rvalid_o(d3_rvalid), .rdata_o(d3_rdata), .err_o(d3_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive0(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
        r0_req = 1'b1; r0_we = we; r0_size = size; r0_uns = uns;
        r0_addr = addr; r0_wdata = wdata;
    endtask

    task automatic drive3(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
        r3_req = 1'b1; r3_we = we; r3_size = size; r3_uns = uns;
        r3_addr = addr; r3_wdata = wdata;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        r0_req = 1'b0; r0_we = 1'b0; r0_size = 2'b10; r0_uns = 1'b0;
        r0_addr = 32'd0; r0_wdata = 32'd0;
        r3_req = 1'b0; r3_we = 1'b0; r3_size = 2'b10; r3_uns = 1'b0;
        r3_addr = 32'd0; r3_wdata = 32'd0;

        // reset values
        step();
        step();
        check("rst_ready0",  32'(d0_ready),  32'd1);
        check("rst_rvalid0", 32'(d0_rvalid), 32'd0);
        check("rst_rdata0",  d0_rdata,       32'd0);
        check("rst_err0",    32'(d0_err),    32'd0);
        check("rst_ready3",  32'(d3_ready),  32'd1);
        check("rst_rvalid3", 32'(d3_rvalid), 32'd0);
        rst = 1'b1;
        step();
        check("idle_rvalid0", 32'(d0_rvalid), 32'd0);

        // WS=0: store word then back-to-back load
        drive0(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        step();
        check("ws0_st_rvalid", 32'(d0_rvalid), 32'd1);
        check("ws0_st_ready",  32'(d0_ready),  32'd1);
        check("ws0_st_rdata",  d0_rdata,       32'd0);
        drive0(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        step();
        check("ws0_ld_rvalid", 32'(d0_rvalid), 32'd1);
        check("ws0_ld_rdata",  d0_rdata,       32'hDEADBEEF);
        check("ws0_ld_ready",  32'(d0_ready),  32'd1);
        r0_req = 1'b0;
        step();
        check("ws0_idle_rvalid", 32'(d0_rvalid), 32'd0);
        check("ws0_hold_rdata",  d0_rdata,       32'hDEADBEEF);

        // byte / half lanes and extension
        drive0(1'b1, 2'b10, 1'b0, 32'h20, 32'h00000000);
        step();
        drive0(1'b1, 2'b00, 1'b0, 32'h21, 32'hABCD1280);
        step();
        drive0(1'b0, 2'b00, 1'b0, 32'h21, 32'h0);
        step();
        check("ldb_signed", d0_rdata, 32'hFFFFFF80);
        drive0(1'b0, 2'b00, 1'b1, 32'h21, 32'h0);
        step();
        check("ldb_unsigned", d0_rdata, 32'h00000080);
        drive0(1'b0, 2'b01, 1'b0, 32'h20, 32'h0);
        step();
        check("ldh_signed", d0_rdata, 32'hFFFF8000);
        drive0(1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFF1234);
        step();
        check("sth_rdata", d0_rdata, 32'd0);
        drive0(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        step();
        check("ldw_after_half", d0_rdata, 32'h12348000);
        drive0(1'b0, 2'b01, 1'b1, 32'h22, 32'h0);
        step();
        check("ldh_unsigned", d0_rdata, 32'h00001234);

        // misaligned accesses
        drive0(1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
        step();
`ifdef DATA_MEM_MISALIGN_ERR_EN
        check("mis_ld_err",   32'(d0_err), 32'd1);
        check("mis_ld_rdata", d0_rdata,    32'd0);
`else
        check("mis_ld_err",   32'(d0_err), 32'd0);
        check("mis_ld_rdata", d0_rdata,    32'hDEADBEEF);
`endif
        drive0(1'b1, 2'b10, 1'b0, 32'h11, 32'h11111111);
        step();
`ifdef DATA_MEM_MISALIGN_ERR_EN
        check("mis_st_err", 32'(d0_err), 32'd1);
`else
        check("mis_st_err", 32'(d0_err), 32'd0);
`endif
        drive0(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        step();
        check("al_ld_err", 32'(d0_err), 32'd0);
`ifdef DATA_MEM_MISALIGN_ERR_EN
        check("al_ld_rdata", d0_rdata, 32'hDEADBEEF);
`else
        check("al_ld_rdata", d0_rdata, 32'h11111111);
`endif

        // aliasing modulo 4*2^ADDR_WIDTH
        drive0(1'b1, 2'b10, 1'b0, 32'h1004, 32'hCAFEF00D);
        step();
        drive0(1'b0, 2'b10, 1'b0, 32'h0004, 32'h0);
        step();
        check("alias_rdata", d0_rdata, 32'hCAFEF00D);
        r0_req = 1'b0;
        step();
        check("alias_idle", 32'(d0_rvalid), 32'd0);

        // WS=3: latency, ready low during BUSY, requests in BUSY ignored
        drive3(1'b1, 2'b10, 1'b0, 32'h40, 32'h5A5A5A5A);
        step();
        drive3(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check("ws3_busy_ready",  32'(d3_ready),  32'd0);
            check("ws3_busy_rvalid", 32'(d3_rvalid), 32'd0);
            step();
        end
        check("ws3_resp_rvalid", 32'(d3_rvalid), 32'd1);
        check("ws3_resp_ready",  32'(d3_ready),  32'd1);
        r3_req = 1'b0;
        step();
        check("ws3_single_pulse", 32'(d3_rvalid), 32'd0);
        check("ws3_idle_ready",   32'(d3_ready),  32'd1);

        drive3(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        step();
        r3_req = 1'b0;
        step();
        step();
        check("ws3_ld_pre", 32'(d3_rvalid), 32'd0);
        step();
        check("ws3_ld_rvalid", 32'(d3_rvalid), 32'd1);
        check("ws3_ld_rdata",  d3_rdata,       32'h5A5A5A5A);

        // reset during BUSY of a store
        step();
        drive3(1'b1, 2'b10, 1'b0, 32'h40, 32'h01234567);
        step();
        r3_req = 1'b0;
        check("abort_busy_ready", 32'(d3_ready), 32'd0);
        rst = 1'b0;
        step();
        check("abort_ready",  32'(d3_ready),  32'd1);
        check("abort_rvalid", 32'(d3_rvalid), 32'd0);
        check("abort_rdata",  d3_rdata,       32'd0);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("abort_no_rvalid", 32'(d3_rvalid), 32'd0);
        end
        drive3(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        step();
        r3_req = 1'b0;
        step();
        step();
        step();
        check("abort_ld_rvalid", 32'(d3_rvalid), 32'd1);
        check("abort_ld_rdata",  d3_rdata,       32'h5A5A5A5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
